// File: rtl/vu_meter_multi_pkg.sv
// Shared types and helpers for the multi-channel VU meter.
// Segment thresholds grow geometrically from a base value.
package vu_meter_multi_pkg;

  localparam int DEFAULT_LEVEL_W = 32;

  typedef logic [DEFAULT_LEVEL_W-1:0] level_t;

  function automatic level_t th_of(input int unsigned base, input int unsigned k,
                                   input int unsigned step);
    return level_t'(base) << (k * step);
  endfunction

endpackage

// File: rtl/vu_meter_multi_if.sv
// Sample-RAM read port: the reader is the master and the meter is the slave.
// The reader drives data, valid and buffer_ready. The meter drives ready.
interface vu_meter_multi_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] ram_read_data;
  logic              ram_read_valid;
  logic              ram_read_ready;
  logic              ram_buffer_ready;

  modport master (
    output ram_read_data, ram_read_valid, ram_buffer_ready,
    input  ram_read_ready
  );

  modport slave (
    input  ram_read_data, ram_read_valid, ram_buffer_ready,
    output ram_read_ready
  );
endinterface

// File: rtl/vu_meter_multi_bar_encoder.sv
// Converts one envelope level into a thermometer bar and a lit-segment count.
// Segment k is lit when the level is strictly above threshold k.
module vu_bar_encoder
  import vu_meter_multi_pkg::*;
#(
  parameter int LEVEL_W       = 32,
  parameter int NUM_LEDS      = 8,
  parameter int TH_BASE       = 1000,
  parameter int TH_STEP_SHIFT = 1,
  parameter int CNT_W         = $clog2(NUM_LEDS + 1)
) (
  input  logic [LEVEL_W-1:0]  level,
  output logic [NUM_LEDS-1:0] bar,
  output logic [CNT_W-1:0]    lit
);

  always_comb begin
    bar = '0;
    lit = '0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      bar[k] = level > LEVEL_W'(th_of(TH_BASE, k, TH_STEP_SHIFT));
      if (bar[k]) lit = lit + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vu_meter_multi.sv
// Multi-channel VU meter: per-channel envelope followers feeding LED bars.
// The bars refresh once per display tick. Defining VU_PEAK_HOLD_EN adds a peak-hold marker.
module vu_meter_multi
  import vu_meter_multi_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int NUM_LEDS      = 8,
  parameter int DATA_W        = 24,
  parameter int LEVEL_W       = DEFAULT_LEVEL_W,
  parameter int SCALE_SHIFT   = 10,
  parameter int ATTACK_SHIFT  = 0,
  parameter int DECAY_SHIFT   = 11,
  parameter int TH_BASE       = 1000,
  parameter int TH_STEP_SHIFT = 1,
  parameter int LED_DIV       = 540000,
  parameter int HOLD_TICKS    = 20
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  vu_meter_multi_if.slave              ram,
  input  logic                         ch_resync_i,
  output logic [NUM_CH*NUM_LEDS-1:0]   leds_o
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DIV_W = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;
  localparam int CNT_W = $clog2(NUM_LEDS + 1);
  localparam int MAG_W = DATA_W - 1;

  logic               busy_q;
  logic [CH_W-1:0]    ch_q;
  logic [DIV_W-1:0]   div_q;
  logic               tick;
  logic               accept;
  logic [LEVEL_W-1:0] level_q [NUM_CH];
  logic [DATA_W-1:0]  neg;
  logic [MAG_W-1:0]   mag;
  logic [LEVEL_W-1:0] scaled;
  logic [LEVEL_W-1:0] cur;
  logic [LEVEL_W-1:0] env_next;
  logic [NUM_LEDS-1:0] bar  [NUM_CH];
  logic [CNT_W-1:0]    lit  [NUM_CH];
  logic [NUM_LEDS-1:0] disp [NUM_CH];

  // Ready is also gated by reset so it drops the moment reset asserts.
  assign ram.ram_read_ready = rst_ni & ~busy_q & ram.ram_buffer_ready;
  assign accept             = ram.ram_read_valid & ram.ram_read_ready;
  assign tick               = (div_q == DIV_W'(LED_DIV - 1));

  // The most negative sample has no positive twin, so it clamps to full scale.
  always_comb begin
    neg = -ram.ram_read_data;
    mag = ram.ram_read_data[MAG_W-1:0];
    if (ram.ram_read_data == {1'b1, {MAG_W{1'b0}}}) mag = '1;
    else if (ram.ram_read_data[DATA_W-1]) mag = neg[MAG_W-1:0];
    scaled = LEVEL_W'(mag >> SCALE_SHIFT);
  end

  always_comb begin
    cur = level_q[ch_q];
    if (scaled > cur) env_next = cur + ((scaled - cur) >> ATTACK_SHIFT);
    else              env_next = cur - (cur >> DECAY_SHIFT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      ch_q   <= '0;
    end else begin
      busy_q <= accept;
      if (ch_resync_i)                      ch_q <= '0;
      else if (accept && ch_q == CH_W'(NUM_CH - 1)) ch_q <= '0;
      else if (accept)                      ch_q <= ch_q + CH_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) level_q[c] <= '0;
    end else if (accept) begin
      for (int c = 0; c < NUM_CH; c++)
        if (ch_q == CH_W'(c)) level_q[c] <= env_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + DIV_W'(1);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_enc
    vu_bar_encoder #(
      .LEVEL_W       (LEVEL_W),
      .NUM_LEDS      (NUM_LEDS),
      .TH_BASE       (TH_BASE),
      .TH_STEP_SHIFT (TH_STEP_SHIFT),
      .CNT_W         (CNT_W)
    ) u_enc (
      .level (level_q[c]),
      .bar   (bar[c]),
      .lit   (lit[c])
    );
  end

`ifdef VU_PEAK_HOLD_EN
  localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  logic [CNT_W-1:0]  peak_q [NUM_CH];
  logic [HOLD_W-1:0] hold_q [NUM_CH];

  // The marker shown on a tick is the peak held before that tick's update.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      disp[c] = bar[c];
      if (peak_q[c] != '0) disp[c] = bar[c] | (NUM_LEDS'(1) << (peak_q[c] - CNT_W'(1)));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) begin
        peak_q[c] <= '0;
        hold_q[c] <= '0;
      end
    end else if (tick) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (lit[c] >= peak_q[c]) begin
          peak_q[c] <= lit[c];
          hold_q[c] <= HOLD_W'(HOLD_TICKS);
        end else if (hold_q[c] == '0) begin
          peak_q[c] <= peak_q[c] - CNT_W'(1);
          hold_q[c] <= HOLD_W'(HOLD_TICKS);
        end else begin
          hold_q[c] <= hold_q[c] - HOLD_W'(1);
        end
      end
    end
  end
`else
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) disp[c] = bar[c];
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      leds_o <= '0;
    end else if (tick) begin
      for (int c = 0; c < NUM_CH; c++) leds_o[c*NUM_LEDS +: NUM_LEDS] <= disp[c];
    end
  end

endmodule
